pueo_command_encoder: RTL and testbench



---
 rtl/pueo_command_pkg.sv | 42 ++++
 rtl/pueo_trig_fifo.sv | 55 +++++
 rtl/pueo_command_encoder.sv | 109 ++++++++++
 tb/tb_pueo_command_encoder.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pueo_command_pkg.sv
// Shared command-word layout for the PUEO command encoder and decoder.
// Bit positions live here so both ends of the link always agree.
package pueo_command_pkg;

    localparam int CMD_WORD_W        = 32;
    localparam int TRIG_TIME_W       = 15;
    localparam int CMDPROC_DATA_W    = 8;

    localparam int TRIG_TIME_LSB     = 0;
    localparam int TRIG_VALID_BIT    = 15;
    localparam int CMDPROC_DATA_LSB  = 16;
    localparam int CMDPROC_VALID_BIT = 24;
    localparam int CMDPROC_LAST_BIT  = 25;
    localparam int CMDPROC_RST_BIT   = 26;
    localparam int PPS_BIT           = 27;
    localparam int SYNC_BIT          = 28;

    // Bits [31:29] are reserved and always zero.
    function automatic logic [CMD_WORD_W-1:0] pack_command(
        input logic [TRIG_TIME_W-1:0]    trig_time,
        input logic                      trig_valid,
        input logic [CMDPROC_DATA_W-1:0] cmdproc_data,
        input logic                      cmdproc_valid,
        input logic                      cmdproc_last,
        input logic                      cmdproc_rst,
        input logic                      pps,
        input logic                      sync
    );
        logic [CMD_WORD_W-1:0] w;
        w = '0;
        w[TRIG_TIME_LSB +: TRIG_TIME_W]       = trig_time;
        w[TRIG_VALID_BIT]                     = trig_valid;
        w[CMDPROC_DATA_LSB +: CMDPROC_DATA_W] = cmdproc_data;
        w[CMDPROC_VALID_BIT]                  = cmdproc_valid;
        w[CMDPROC_LAST_BIT]                   = cmdproc_last;
        w[CMDPROC_RST_BIT]                    = cmdproc_rst;
        w[PPS_BIT]                            = pps;
        w[SYNC_BIT]                           = sync;
        return w;
    endfunction

endpackage

// File: rtl/pueo_trig_fifo.sv
// Small trigger-time FIFO; DEPTH must be a power of two so pointers wrap freely.
// A push while full is taken only if a pop frees a slot in the same cycle.
module pueo_trig_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst_n && do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pueo_command_encoder.sv
// Builds one 32-bit command word per 16-cycle sync period from pending requests,
// at most one cmdproc byte and the oldest queued trigger time.
module pueo_command_encoder
    import pueo_command_pkg::*;
#(
    parameter int TRIG_FIFO_DEPTH = 4
) (
    input  logic                   sysclk_i,
    input  logic                   rst_n_i,
    input  logic                   sync_i,
    input  logic                   cmdsync_req_i,
    input  logic                   cmdpps_req_i,
    input  logic                   cmdproc_rst_req_i,
    input  logic [7:0]             cmdproc_tdata,
    input  logic                   cmdproc_tvalid,
    input  logic                   cmdproc_tlast,
    output logic                   cmdproc_tready,
    input  logic [14:0]            trig_time_i,
    input  logic                   trig_valid_i,
    output logic [31:0]            command_o,
    output logic                   command_valid_o,
    output logic                   trig_overflow_o,
    output logic [7:0]             trig_overflow_count_o
);

    logic                   pend_sync;
    logic                   pend_pps;
    logic                   pend_rst;
    logic                   word_sync;
    logic                   word_pps;
    logic                   word_rst;
    logic                   byte_accept;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   fifo_pop;
    logic [TRIG_TIME_W-1:0] fifo_data;
    logic                   trig_drop;
    logic [CMD_WORD_W-1:0]  next_word;

    // cmdproc stream: a byte transfers on a cycle where tvalid && tready are both
    // high; tready is offered only on sync cycles with no cmdproc reset in flight,
    // so the reset word never carries a byte.
    assign cmdproc_tready = sync_i & rst_n_i & ~(pend_rst | cmdproc_rst_req_i);
    assign byte_accept    = cmdproc_tvalid & cmdproc_tready;

    assign word_sync = pend_sync | cmdsync_req_i;
    assign word_pps  = pend_pps  | cmdpps_req_i;
    assign word_rst  = pend_rst  | cmdproc_rst_req_i;

    // Pop reads the entry present before this edge, so a same-cycle push is never bypassed.
    assign fifo_pop  = sync_i & ~fifo_empty;
    assign trig_drop = trig_valid_i & fifo_full & ~fifo_pop;

    always_comb begin
        next_word = pack_command(
            fifo_pop ? fifo_data : '0,
            fifo_pop,
            byte_accept ? cmdproc_tdata : 8'h00,
            byte_accept,
            byte_accept & cmdproc_tlast,
            word_rst,
            word_pps,
            word_sync
        );
    end

    pueo_trig_fifo #(
        .DEPTH (TRIG_FIFO_DEPTH),
        .WIDTH (TRIG_TIME_W)
    ) u_trig_fifo (
        .clk       (sysclk_i),
        .rst_n     (rst_n_i),
        .push      (trig_valid_i),
        .push_data (trig_time_i),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge sysclk_i) begin
        if (!rst_n_i) begin
            pend_sync             <= 1'b0;
            pend_pps              <= 1'b0;
            pend_rst              <= 1'b0;
            command_o             <= '0;
            command_valid_o       <= 1'b0;
            trig_overflow_o       <= 1'b0;
            trig_overflow_count_o <= '0;
        end else begin
            if (sync_i) begin
                pend_sync <= 1'b0;
                pend_pps  <= 1'b0;
                pend_rst  <= 1'b0;
                command_o <= next_word;
            end else begin
                pend_sync <= word_sync;
                pend_pps  <= word_pps;
                pend_rst  <= word_rst;
            end
            command_valid_o <= sync_i;
            trig_overflow_o <= trig_drop;
            if (trig_drop && trig_overflow_count_o != 8'hFF) begin
                trig_overflow_count_o <= trig_overflow_count_o + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_pueo_command_encoder.sv
// Directed bench for pueo_command_encoder: each task drives one scenario and
// checks the produced command words against hand-computed values.
module tb_pueo_command_encoder;

    logic        sysclk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        sync_i = 1'b0;
    logic        cmdsync_req_i = 1'b0;
    logic        cmdpps_req_i = 1'b0;
    logic        cmdproc_rst_req_i = 1'b0;
    logic [7:0]  cmdproc_tdata = 8'h00;
    logic        cmdproc_tvalid = 1'b0;
    logic        cmdproc_tlast = 1'b0;
    logic        cmdproc_tready;
    logic [14:0] trig_time_i = 15'h0;
    logic        trig_valid_i = 1'b0;
    logic [31:0] command_o;
    logic        command_valid_o;
    logic        trig_overflow_o;
    logic [7:0]  trig_overflow_count_o;

    int   tests_run = 0;
    int   tests_failed = 0;
    int   phase = 0;
    logic last_tready;
    logic [31:0] exp_q[$];

    pueo_command_encoder #(.TRIG_FIFO_DEPTH(4)) dut (
        .sysclk_i              (sysclk_i),
        .rst_n_i               (rst_n_i),
        .sync_i                (sync_i),
        .cmdsync_req_i         (cmdsync_req_i),
        .cmdpps_req_i          (cmdpps_req_i),
        .cmdproc_rst_req_i     (cmdproc_rst_req_i),
        .cmdproc_tdata         (cmdproc_tdata),
        .cmdproc_tvalid        (cmdproc_tvalid),
        .cmdproc_tlast         (cmdproc_tlast),
        .cmdproc_tready        (cmdproc_tready),
        .trig_time_i           (trig_time_i),
        .trig_valid_i          (trig_valid_i),
        .command_o             (command_o),
        .command_valid_o       (command_valid_o),
        .trig_overflow_o       (trig_overflow_o),
        .trig_overflow_count_o (trig_overflow_count_o)
    );

    // Clock / reset block: reset is driven by the test tasks.
    always #5 sysclk_i = ~sysclk_i;

    // One clock: sync_i on phase 0 of every 16, pulse inputs cleared after the edge.
    task automatic cycle();
        sync_i = (phase == 0);
        #1 last_tready = cmdproc_tready;
        @(posedge sysclk_i);
        #1;
        phase = (phase + 1) % 16;
        cmdsync_req_i     = 1'b0;
        cmdpps_req_i      = 1'b0;
        cmdproc_rst_req_i = 1'b0;
        trig_valid_i      = 1'b0;
    endtask

    task automatic goto_phase(input int p);
        while (phase != p) cycle();
    endtask

    task automatic next_word(output logic [31:0] w);
        w = 'x;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (command_valid_o === 1'b1) begin
                w = command_o;
                return;
            end
        end
        tests_run++;
        tests_failed++;
        $display("FAIL word_timeout: no command_valid_o within 20 cycles");
    endtask

    task automatic test_reset();
        logic [31:0] w;
        rst_n_i = 1'b0;
        cmdsync_req_i = 1'b1;
        trig_time_i = 15'h0123;
        trig_valid_i = 1'b1;
        cycle();
        tests_run++;
        if (last_tready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_tready: got %b expected 0", last_tready);
        end
        cmdpps_req_i = 1'b1;
        cycle();
        tests_run++;
        if (command_o !== 32'h0 || command_valid_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_word: got %h/%b expected 00000000/0", command_o, command_valid_o);
        end
        tests_run++;
        if (trig_overflow_o !== 1'b0 || trig_overflow_count_o !== 8'd0) begin
            tests_failed++;
            $display("FAIL reset_overflow: got %b/%0d expected 0/0", trig_overflow_o, trig_overflow_count_o);
        end
        rst_n_i = 1'b1;
        next_word(w);
        tests_run++;
        if (w !== 32'h0000_0000) begin
            tests_failed++;
            $display("FAIL reset_first_word: got %h expected 00000000", w);
        end
    endtask

    task automatic test_sync_req();
        logic [31:0] w;
        goto_phase(5);
        cmdsync_req_i = 1'b1;
        cycle();
        next_word(w);
        tests_run++;
        if (w !== 32'h1000_0000) begin
            tests_failed++;
            $display("FAIL sync_req_word: got %h expected 10000000", w);
        end
        tests_run++;
        if (phase != 1) begin
            tests_failed++;
            $display("FAIL sync_req_latency: valid seen at phase %0d expected 1", phase);
        end
        cycle();
        tests_run++;
        if (command_valid_o !== 1'b0 || command_o !== 32'h1000_0000) begin
            tests_failed++;
            $display("FAIL sync_req_hold: got %h/%b expected 10000000/0", command_o, command_valid_o);
        end
    endtask

    task automatic test_stream();
        logic [31:0] w;
        goto_phase(3);
        cmdproc_tdata = 8'hA5;
        cmdproc_tlast = 1'b0;
        cmdproc_tvalid = 1'b1;
        cycle();
        tests_run++;
        if (last_tready !== 1'b0) begin
            tests_failed++;
            $display("FAIL stream_tready_idle: got %b expected 0", last_tready);
        end
        next_word(w);
        tests_run++;
        if (last_tready !== 1'b1) begin
            tests_failed++;
            $display("FAIL stream_tready_sync: got %b expected 1", last_tready);
        end
        tests_run++;
        if (w !== 32'h01A5_0000) begin
            tests_failed++;
            $display("FAIL stream_byte0: got %h expected 01A50000", w);
        end
        cmdproc_tdata = 8'h3C;
        cmdproc_tlast = 1'b1;
        next_word(w);
        tests_run++;
        if (w !== 32'h033C_0000) begin
            tests_failed++;
            $display("FAIL stream_byte1: got %h expected 033C0000", w);
        end
        cmdproc_tvalid = 1'b0;
        cmdproc_tlast = 1'b0;
    endtask

    task automatic test_rst_req();
        logic [31:0] w;
        goto_phase(4);
        cmdproc_rst_req_i = 1'b1;
        cmdproc_tdata = 8'h11;
        cmdproc_tvalid = 1'b1;
        cycle();
        next_word(w);
        tests_run++;
        if (w !== 32'h0400_0000 || last_tready !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_req_word: got %h tready %b expected 04000000 tready 0", w, last_tready);
        end
        next_word(w);
        tests_run++;
        if (w !== 32'h0111_0000) begin
            tests_failed++;
            $display("FAIL rst_req_byte: got %h expected 01110000", w);
        end
        cmdproc_tvalid = 1'b0;
    endtask

    task automatic test_fifo_overflow();
        logic [31:0] w;
        logic [31:0] exp;
        goto_phase(1);
        for (int i = 1; i <= 5; i++) begin
            trig_time_i = 15'(i);
            trig_valid_i = 1'b1;
            cycle();
        end
        tests_run++;
        if (trig_overflow_o !== 1'b1 || trig_overflow_count_o !== 8'd1) begin
            tests_failed++;
            $display("FAIL ovf_pulse: got %b/%0d expected 1/1", trig_overflow_o, trig_overflow_count_o);
        end
        cycle();
        tests_run++;
        if (trig_overflow_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL ovf_pulse_width: got %b expected 0", trig_overflow_o);
        end
        exp_q = {32'h0000_8001, 32'h0000_8002, 32'h0000_8003, 32'h0000_8004, 32'h0000_0000};
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            next_word(w);
            tests_run++;
            if (w !== exp) begin
                tests_failed++;
                $display("FAIL ovf_drain: got %h expected %h", w, exp);
            end
        end
        tests_run++;
        if (trig_overflow_count_o !== 8'd1) begin
            tests_failed++;
            $display("FAIL ovf_count_hold: got %0d expected 1", trig_overflow_count_o);
        end
    endtask

    task automatic test_full_push_pop();
        logic [31:0] w;
        logic [31:0] exp;
        goto_phase(1);
        for (int i = 0; i < 4; i++) begin
            trig_time_i = 15'h10 + 15'(i);
            trig_valid_i = 1'b1;
            cycle();
        end
        goto_phase(0);
        trig_time_i = 15'h14;
        trig_valid_i = 1'b1;
        next_word(w);
        tests_run++;
        if (w !== 32'h0000_8010 || trig_overflow_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL full_push_pop: got %h ovf %b expected 00008010 ovf 0", w, trig_overflow_o);
        end
        exp_q = {32'h0000_8011, 32'h0000_8012, 32'h0000_8013, 32'h0000_8014};
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            next_word(w);
            tests_run++;
            if (w !== exp) begin
                tests_failed++;
                $display("FAIL full_drain: got %h expected %h", w, exp);
            end
        end
        tests_run++;
        if (trig_overflow_count_o !== 8'd1) begin
            tests_failed++;
            $display("FAIL full_no_drop: got %0d expected 1", trig_overflow_count_o);
        end
    endtask

    task automatic test_no_bypass();
        logic [31:0] w;
        goto_phase(0);
        trig_time_i = 15'h7FFF;
        trig_valid_i = 1'b1;
        next_word(w);
        tests_run++;
        if (w !== 32'h0000_0000) begin
            tests_failed++;
            $display("FAIL no_bypass_same: got %h expected 00000000", w);
        end
        next_word(w);
        tests_run++;
        if (w !== 32'h0000_FFFF) begin
            tests_failed++;
            $display("FAIL no_bypass_next: got %h expected 0000FFFF", w);
        end
    endtask

    task automatic test_pps_and_reset();
        logic [31:0] w;
        goto_phase(0);
        cmdpps_req_i = 1'b1;
        next_word(w);
        tests_run++;
        if (w !== 32'h0800_0000) begin
            tests_failed++;
            $display("FAIL pps_same_cycle: got %h expected 08000000", w);
        end
        goto_phase(3);
        cmdsync_req_i = 1'b1;
        trig_time_i = 15'h22;
        trig_valid_i = 1'b1;
        cycle();
        goto_phase(7);
        rst_n_i = 1'b0;
        cmdpps_req_i = 1'b1;
        cycle();
        rst_n_i = 1'b1;
        tests_run++;
        if (command_o !== 32'h0 || trig_overflow_count_o !== 8'd0) begin
            tests_failed++;
            $display("FAIL midreset_clear: got %h/%0d expected 00000000/0", command_o, trig_overflow_count_o);
        end
        next_word(w);
        tests_run++;
        if (w !== 32'h0000_0000) begin
            tests_failed++;
            $display("FAIL midreset_word: got %h expected 00000000", w);
        end
    endtask

    task automatic test_saturate();
        goto_phase(1);
        for (int i = 0; i < 400; i++) begin
            trig_time_i = 15'(i);
            trig_valid_i = 1'b1;
            cycle();
        end
        tests_run++;
        if (trig_overflow_count_o !== 8'd255) begin
            tests_failed++;
            $display("FAIL ovf_saturate: got %0d expected 255", trig_overflow_count_o);
        end
    endtask

    initial begin
        test_reset();
        test_sync_req();
        test_stream();
        test_rst_req();
        test_fifo_overflow();
        test_full_push_pop();
        test_no_bypass();
        test_pps_and_reset();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
